// File: rtl/serial_transmitter.sv
// serial_transmitter: 7-bit even-parity framed serializer with a one-word holding register
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int START_BITS   = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [6:0] data_in,
  output logic       in_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       tx_done
);
  localparam int SL = START_BITS * CLKS_PER_BIT;
  localparam int PL = STOP_BITS * CLKS_PER_BIT;
  localparam int PW = $clog2(CLKS_PER_BIT + 1);
  localparam int SW = $clog2(SL + 1);
  localparam int TW = $clog2(PL + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [PW-1:0] pcnt;
  logic [2:0] bit_idx;
  logic [SW-1:0] st_cnt;
  logic [TW-1:0] sp_cnt;
  logic [7:0] sh;
  logic [6:0] hold;
  logic bit_end;
  assign bit_end = pcnt == PW'(CLKS_PER_BIT - 1);
  // in_ready doubles as the holding register's empty flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      bit_idx    <= '0;
      st_cnt     <= '0;
      sp_cnt     <= '0;
      sh         <= '0;
      hold       <= '0;
      in_ready   <= 1'b1;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (in_valid && in_ready) begin
        hold     <= data_in;
        in_ready <= 1'b0;
      end
      case (state)
        IDLE: if (!in_ready) begin
          state      <= START;
          sh         <= {^hold, hold};
          in_ready   <= 1'b1;
          serial_out <= 1'b0;
          busy       <= 1'b1;
        end
        START: if (st_cnt == SW'(SL - 1)) begin
          st_cnt     <= '0;
          state      <= DATA;
          serial_out <= sh[0];
        end else st_cnt <= st_cnt + 1'b1;
        DATA: if (bit_end) begin
          pcnt       <= '0;
          sh         <= sh >> 1;
          serial_out <= sh[1];
          bit_idx    <= bit_idx == 3'd6 ? 3'd0 : bit_idx + 3'd1;
          if (bit_idx == 3'd6) state <= PARITY;
        end else pcnt <= pcnt + 1'b1;
        PARITY: if (bit_end) begin
          pcnt       <= '0;
          state      <= STOP;
          serial_out <= 1'b1;
          tx_done    <= PL == 1;
        end else pcnt <= pcnt + 1'b1;
        STOP: begin
          // registered pulse: raise it one edge ahead so it covers the last stop cycle
          tx_done <= 32'(sp_cnt) + 2 == PL;
          if (sp_cnt == TW'(PL - 1)) begin
            sp_cnt <= '0;
            if (!in_ready) begin
              state      <= START;
              sh         <= {^hold, hold};
              in_ready   <= 1'b1;
              serial_out <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else sp_cnt <= sp_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Serializes 7-bit data words into the team's single-wire framed serial format: a low start interval, 7 data bits LSB first, one even-parity bit, then a high stop/idle interval. It is the transmit end of the link consumed by the existing serial receiver. It sits between a producer using a valid/ready handshake and the serial line. A one-word holding register lets the producer queue the next word while the current frame is on the wire, so consecutive frames can be sent back-to-back.

## Interface
- CLKS_PER_BIT, default 1: clock cycles per bit period; legal range ≥1.
- START_BITS, default 2: start interval length in bit periods (line low); legal range ≥1. The value 2 matches the receiver's sampling alignment.
- STOP_BITS, default 1: minimum stop/idle interval in bit periods (line high) after parity; legal range ≥1.
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers data_in this cycle.
- data_in  input  7  word to transmit.
- in_ready  output  1  holding register empty; transfer occurs on an edge where in_valid && in_ready.
- serial_out  output  1  serial line; idle high.
- busy  output  1  high while the FSM is in any state except IDLE.
- tx_done  output  1  one-cycle pulse when a frame's stop interval completes.

## Operation
- Reset values: serial_out=1, in_ready=1, busy=0, tx_done=0. Holding register empty, FSM in IDLE, all counters 0.
- Holding register:
  - Loads data_in on an accept edge and becomes full (in_ready=0).
  - Empties on the edge where the FSM copies it into the shifter.
  - A simultaneous accept and copy is impossible, because accept requires empty.
- Shifter: 8 bits = {parity, data}. Parity = XOR of the 7 data bits, so the 8 transmitted bits contain an even number of ones.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_out=1. If the holding register is full, go to START, load the shifter and empty the holding register.
  - START: serial_out=0 for START_BITS*CLKS_PER_BIT cycles, then DATA.
  - DATA: serial_out=shifter[0]. Shift right once per bit period. After 7 bit periods, go to PARITY.
  - PARITY: serial_out=parity for one bit period, then STOP.
  - STOP: serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, assert tx_done.
    - If the holding register is full, go directly to START and load the next word (no extra idle).
    - Otherwise go to IDLE.
- Counters: bit-period counter counts 0..CLKS_PER_BIT-1; bit index counts 0..6; start and stop counters are sized for their parameters. All wrap cleanly to 0 on state exit.
- in_valid while in_ready=0 is ignored; the producer must hold it. data_in is sampled only on the accept edge.
- Asserting rst mid-frame immediately forces serial_out=1 and drops both the in-flight word and the held word. After release, the next accepted word starts a fresh frame.

## Timing
- Accept on edge t with the FSM idle:
  - Edge t+1: START; serial_out falls; in_ready returns to 1.
- Frame length with defaults: 2+7+1+1 = 11 cycles. In general: (START_BITS+8+STOP_BITS)*CLKS_PER_BIT.
- Defaults, accept at edge t:
  - Start low during cycles t+1..t+2.
  - d0..d6 during t+3..t+9.
  - Parity during t+10.
  - Stop during t+11.
  - tx_done high during t+11; busy falls after edge t+12 if nothing is queued.
- Back-to-back: with a word held before the end of STOP, the next start bit begins the cycle right after the last stop cycle. Sustained throughput is one frame per frame-length.
- Latency from accept to first line transition is one cycle.
- Outputs are registered and glitch-free. serial_out changes only on clk edges or on rst assertion.

## Test plan
- Reset check: hold rst, then release. Expect serial_out=1, in_ready=1, busy=0, tx_done=0. No line activity without in_valid.
- Single frame, defaults: send 7'h55. Expect the line sequence 0,0,1,0,1,0,1,0,1,0,1 (parity 0), tx_done pulsed in the stop cycle, then idle high.
- Parity cases: 7'h01 gives parity bit 1; 7'h7F gives parity bit 1; 7'h00 gives parity bit 0. The total count of ones over the 8 bits is even in every case.
- Back-to-back: accept 7'h2A, then 7'h15 while busy. in_ready drops until the second word is copied. The second start bit directly follows the first stop cycle. Expect two tx_done pulses 11 cycles apart.
- CLKS_PER_BIT=4, STOP_BITS=2: send 7'h3C. Expect each bit held exactly 4 cycles and a frame of 48 cycles.
- Reset mid-DATA on 7'h7F with a word held: serial_out goes high immediately and the held word is discarded. A new word after release transmits correctly, checked by loopback into the serial receiver: data_out matches and parity_ok_n=0.
